// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the two-requester APB master:
//   apb_state_e     - bus-phase FSM states (IDLE / SETUP / ACCESS)
//   NUM_REQ         - number of requesters sharing the master (2)
//   DEFAULT_TIMEOUT - default ACCESS-cycle budget before a transfer is aborted
//   onehot_to_idx   - converts a one-hot grant vector to a requester index
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int NUM_REQ         = 2;
  localparam int DEFAULT_TIMEOUT = 16;

  // Index of the set bit in a one-hot two-requester grant (0 when bit 0 or none).
  function automatic logic onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    return oh[1] & ~oh[0];
  endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// -----------------------------------------------------------------------------
// apb_arb_master_if
// Bundles the requester-side handshake and the APB bus of apb_arb_master.
//   Requester side : req_valid/req_write/req_addr/req_wdata in, req_ready out,
//                    rsp_valid/rsp_rdata/rsp_err/rsp_timeout out.
//   APB side       : PADDR/PWRITE/PWDATA/PSELx/PENABLE out,
//                    PREADY/PRDATA/PSLVERR in.
//   Status         : busy out.
// Modport master is the arbitrating APB master; modport slave is the
// environment (requesters plus APB slave).
// -----------------------------------------------------------------------------
interface apb_arb_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [apb_pkg::NUM_REQ-1:0]            req_valid;
  logic [apb_pkg::NUM_REQ-1:0]            req_write;
  logic [apb_pkg::NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [apb_pkg::NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [apb_pkg::NUM_REQ-1:0]            req_ready;
  logic [apb_pkg::NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]                  rsp_rdata;
  logic                                   rsp_err;
  logic                                   rsp_timeout;
  logic [ADDR_WIDTH-1:0]                  PADDR;
  logic                                   PWRITE;
  logic [DATA_WIDTH-1:0]                  PWDATA;
  logic                                   PSELx;
  logic                                   PENABLE;
  logic                                   PREADY;
  logic [DATA_WIDTH-1:0]                  PRDATA;
  logic                                   PSLVERR;
  logic                                   busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWRITE, PWDATA, PSELx, PENABLE, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWRITE, PWDATA, PSELx, PENABLE, busy
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational round-robin grant for two requesters.
//   req        in  : request vector
//   last_grant in  : index of the requester granted most recently
//   grant      out : one-hot grant (all zero when nothing is requested)
// A lone requester always wins; under contention the one not granted last wins.
// -----------------------------------------------------------------------------
module apb_rr_arbiter
  import apb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // Round-robin pick between the two requesters.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_arb_master.sv
// -----------------------------------------------------------------------------
// apb_arb_master
// APB master shared by two requesters through a round-robin arbiter.
//   PCLK   in : bus clock
//   PRESET in : asynchronous active-high reset
//   bus       : apb_arb_master_if.master (requester handshake, APB bus, busy)
// Timeline of a transfer with zero wait states: req_ready pulses at edge T
// (state still IDLE), SETUP phase from T+1, ACCESS phase from T+2, rsp_valid
// pulses at T+3. A slave that keeps PREADY low for TIMEOUT ACCESS cycles gets
// the transfer aborted with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
// -----------------------------------------------------------------------------
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_arb_master_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e             state_r;
  apb_state_e             state_next_s;
  logic [CNT_W-1:0]       wait_cnt_r;
  logic                   last_grant_r;
  logic                   owner_r;
  logic [NUM_REQ-1:0]     arb_req_s;
  logic [NUM_REQ-1:0]     grant_s;
  logic                   grant_idx_s;
  logic                   done_s;
  logic                   abort_s;
  logic                   wait_inc_s;
  logic [NUM_REQ-1:0]     req_ready_r;
  logic [NUM_REQ-1:0]     rsp_valid_r;
  logic [DATA_WIDTH-1:0]  rsp_rdata_r;
  logic                   rsp_err_r;
  logic                   rsp_timeout_r;
  logic [ADDR_WIDTH-1:0]  paddr_r;
  logic                   pwrite_r;
  logic [DATA_WIDTH-1:0]  pwdata_r;
  logic                   psel_r;
  logic                   penable_r;
  logic                   busy_r;

  // Requests reach the arbiter only in an IDLE cycle that is not already
  // carrying an accept pulse, so one IDLE visit yields at most one grant.
  always_comb begin
    if ((state_r == IDLE) && (req_ready_r == 2'b00)) begin
      arb_req_s = bus.req_valid;
    end else begin
      arb_req_s = 2'b00;
    end
  end

  apb_rr_arbiter u_arb (
    .req        (arb_req_s),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  assign grant_idx_s = onehot_to_idx(grant_s);

  // Next-state decode and ACCESS-phase completion / abort detection.
  always_comb begin
    state_next_s = state_r;
    done_s       = 1'b0;
    abort_s      = 1'b0;
    wait_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // The accept pulse cycle is the last IDLE cycle of a granted transfer.
        if (req_ready_r != 2'b00) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          state_next_s = IDLE;
          done_s       = 1'b1;
        end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th one without PREADY.
          state_next_s = IDLE;
          abort_s      = 1'b1;
        end else begin
          state_next_s = ACCESS;
          wait_inc_s   = 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register and ACCESS wait counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == IDLE) && (state_next_s == SETUP)) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if (wait_inc_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Accept pulse, ownership and capture of the granted request.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      req_ready_r  <= 2'b00;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      paddr_r      <= {ADDR_WIDTH{1'b0}};
      pwrite_r     <= 1'b0;
      pwdata_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      req_ready_r <= grant_s;
      if (grant_s != 2'b00) begin
        last_grant_r <= grant_idx_s;
        owner_r      <= grant_idx_s;
        paddr_r      <= grant_idx_s ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : bus.req_addr[ADDR_WIDTH-1:0];
        pwdata_r     <= grant_idx_s ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : bus.req_wdata[DATA_WIDTH-1:0];
        pwrite_r     <= bus.req_write[grant_idx_s];
      end else begin
        last_grant_r <= last_grant_r;
        owner_r      <= owner_r;
        paddr_r      <= paddr_r;
        pwdata_r     <= pwdata_r;
        pwrite_r     <= pwrite_r;
      end
    end
  end

  // APB phase strobes and busy, registered from the next state so they line
  // up with the state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      psel_r    <= (state_next_s == SETUP) || (state_next_s == ACCESS);
      penable_r <= (state_next_s == ACCESS);
      busy_r    <= (state_next_s != IDLE);
    end
  end

  // Completion response to the owning requester; data and status hold
  // between pulses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid_r   <= 2'b00;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else if (done_s) begin
      rsp_valid_r   <= owner_r ? 2'b10 : 2'b01;
      rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
      rsp_err_r     <= bus.PSLVERR;
      rsp_timeout_r <= 1'b0;
    end else if (abort_s) begin
      rsp_valid_r   <= owner_r ? 2'b10 : 2'b01;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_err_r     <= 1'b1;
      rsp_timeout_r <= 1'b1;
    end else begin
      rsp_valid_r   <= 2'b00;
      rsp_rdata_r   <= rsp_rdata_r;
      rsp_err_r     <= rsp_err_r;
      rsp_timeout_r <= rsp_timeout_r;
    end
  end

  assign bus.req_ready   = req_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.PSELx       = psel_r;
  assign bus.PENABLE     = penable_r;
  assign bus.busy        = busy_r;

endmodule
